// File: rtl/ssd1306_procedure_scheduler_pkg.sv
// Shared types and default ROM offsets for the SSD1306 procedure scheduler.
// The offset defaults must stay in sync with the microcode ROM build.
package ssd1306_pkg;

    typedef enum logic [1:0] {
        KIND_INIT,
        KIND_OFF,
        KIND_REFRESH
    } proc_kind_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE
    } sched_state_t;

    localparam int DEFAULT_MICROCODE_SIZE   = 48;
    localparam int DEFAULT_OFFSET_INIT      = 0;
    localparam int DEFAULT_OFFSET_POWER_OFF = 24;
    localparam int DEFAULT_OFFSET_REFRESH   = 36;

    // Folds an offset into the ROM range so an out-of-range value never
    // addresses past the end of the executor ROM.
    function automatic int fold_offset(input int offset, input int size);
        return (offset < size) ? offset : (offset % size);
    endfunction

endpackage

// File: rtl/ssd1306_procedure_scheduler_if.sv
// Handshake between the scheduler (master) and the microcode executor (slave).
interface ssd1306_procedure_scheduler_if #(
    parameter int ADDR_BITS = 6
);
    logic [ADDR_BITS-1:0] procedure_offset_out;
    logic                 procedure_start_out;
    logic                 procedure_done_in;
    logic                 spi_ready_in;

    modport master (
        output procedure_offset_out,
        output procedure_start_out,
        input  procedure_done_in,
        input  spi_ready_in
    );

    modport slave (
        input  procedure_offset_out,
        input  procedure_start_out,
        output procedure_done_in,
        output spi_ready_in
    );
endinterface

// File: rtl/ssd1306_refresh_timer.sv
// Free-running period counter; emits a one-cycle tick on the last count and
// sits at zero whenever it is disabled.
module ssd1306_refresh_timer #(
    parameter int PERIOD = 20000
) (
    input  logic clk_in,
    input  logic resetn_in,
    input  logic enable,
    output logic tick
);
    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    // Count 0..PERIOD-1 while enabled, wrap at the end, clear when disabled.
    always_ff @(posedge clk_in) begin
        if (!resetn_in || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);
endmodule

// File: rtl/ssd1306_procedure_scheduler.sv
// Picks which microcode procedure the SSD1306 executor runs next (power-off,
// init, refresh), starts it, and tracks panel power state.
module ssd1306_procedure_scheduler
    import ssd1306_pkg::*;
#(
    parameter int MICROCODE_SIZE   = DEFAULT_MICROCODE_SIZE,
    parameter int OFFSET_INIT      = DEFAULT_OFFSET_INIT,
    parameter int OFFSET_POWER_OFF = DEFAULT_OFFSET_POWER_OFF,
    parameter int OFFSET_REFRESH   = DEFAULT_OFFSET_REFRESH,
    parameter int REFRESH_PERIOD   = 20000,
    parameter int START_TIMEOUT    = 15,
    parameter int AUTO_INIT        = 1
) (
    input  logic clk_in,
    input  logic resetn_in,
    input  logic power_on_req_in,
    input  logic power_off_req_in,
    input  logic refresh_req_in,
    input  logic auto_refresh_en_in,
    ssd1306_procedure_scheduler_if.master exec_if,
    output logic busy_out,
    output logic powered_out,
    output logic frame_done_out,
    output logic error_out
);
    localparam int ADDR_BITS = $clog2(MICROCODE_SIZE);
    localparam int TW        = $clog2(START_TIMEOUT + 1);

    localparam logic [ADDR_BITS-1:0] ADDR_INIT    = ADDR_BITS'(fold_offset(OFFSET_INIT, MICROCODE_SIZE));
    localparam logic [ADDR_BITS-1:0] ADDR_OFF     = ADDR_BITS'(fold_offset(OFFSET_POWER_OFF, MICROCODE_SIZE));
    localparam logic [ADDR_BITS-1:0] ADDR_REFRESH = ADDR_BITS'(fold_offset(OFFSET_REFRESH, MICROCODE_SIZE));
    localparam logic [TW-1:0]        START_LAST   = TW'(START_TIMEOUT - 1);

    sched_state_t         state_q, state_d;
    proc_kind_t           kind_q, kind_d;
    logic [ADDR_BITS-1:0] offset_q, offset_d;
    logic [TW-1:0]        start_cnt_q, start_cnt_d;
    logic                 start_q, start_d;
    logic                 powered_q, powered_d;
    logic                 frame_done_q, frame_done_d;
    logic                 error_q, error_d;
    logic                 pend_on_q, pend_on_d;
    logic                 pend_off_q, pend_off_d;
    logic                 pend_refresh_q, pend_refresh_d;
    logic                 timer_tick;
    logic                 init_in_flight;
    logic                 set_on, set_off, set_refresh, drop_on;
    logic                 off_complete;

    ssd1306_refresh_timer #(
        .PERIOD (REFRESH_PERIOD)
    ) u_refresh_timer (
        .clk_in    (clk_in),
        .resetn_in (resetn_in),
        .enable    (powered_q && auto_refresh_en_in),
        .tick      (timer_tick)
    );

    assign init_in_flight = (state_q != S_IDLE) && (kind_q == KIND_INIT);
    assign set_on         = power_on_req_in && !powered_q;
    assign set_refresh    = (refresh_req_in || timer_tick) && powered_q;
    assign set_off        = power_off_req_in && (powered_q || init_in_flight);
    assign drop_on        = power_off_req_in && !powered_q && !init_in_flight;

    // Register all scheduler state; reset re-arms the init request if enabled.
    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            state_q        <= S_IDLE;
            kind_q         <= KIND_INIT;
            offset_q       <= '0;
            start_cnt_q    <= '0;
            start_q        <= 1'b0;
            powered_q      <= 1'b0;
            frame_done_q   <= 1'b0;
            error_q        <= 1'b0;
            pend_on_q      <= (AUTO_INIT != 0);
            pend_off_q     <= 1'b0;
            pend_refresh_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            offset_q       <= offset_d;
            start_cnt_q    <= start_cnt_d;
            start_q        <= start_d;
            powered_q      <= powered_d;
            frame_done_q   <= frame_done_d;
            error_q        <= error_d;
            pend_on_q      <= pend_on_d;
            pend_off_q     <= pend_off_d;
            pend_refresh_q <= pend_refresh_d;
        end
    end

    // Dispatch, start handshake and completion handling, then fold in new
    // requests so that a fresh request survives a same-cycle dispatch clear.
    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        offset_d       = offset_q;
        start_cnt_d    = start_cnt_q;
        start_d        = start_q;
        powered_d      = powered_q;
        frame_done_d   = 1'b0;
        error_d        = error_q;
        pend_on_d      = pend_on_q;
        pend_off_d     = pend_off_q;
        pend_refresh_d = pend_refresh_q;
        off_complete   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (exec_if.procedure_done_in && exec_if.spi_ready_in &&
                    (pend_off_q || pend_on_q || pend_refresh_q)) begin
                    start_d     = 1'b1;
                    start_cnt_d = '0;
                    state_d     = S_START;
                    if (pend_off_q) begin
                        kind_d     = KIND_OFF;
                        offset_d   = ADDR_OFF;
                        pend_off_d = 1'b0;
                    end else if (pend_on_q) begin
                        kind_d    = KIND_INIT;
                        offset_d  = ADDR_INIT;
                        pend_on_d = 1'b0;
                    end else begin
                        kind_d         = KIND_REFRESH;
                        offset_d       = ADDR_REFRESH;
                        pend_refresh_d = 1'b0;
                    end
                end
            end
            S_START: begin
                if (!exec_if.procedure_done_in) begin
                    start_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end else if (start_cnt_q == START_LAST) begin
                    start_d = 1'b0;
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (exec_if.procedure_done_in) begin
                    case (kind_q)
                        KIND_INIT:    powered_d = 1'b1;
                        KIND_OFF: begin
                            powered_d    = 1'b0;
                            off_complete = 1'b1;
                        end
                        KIND_REFRESH: frame_done_d = 1'b1;
                        default:      frame_done_d = 1'b0;
                    endcase
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (set_on)       pend_on_d      = 1'b1;
        if (drop_on)      pend_on_d      = 1'b0;
        if (set_off)      pend_off_d     = 1'b1;
        if (set_refresh)  pend_refresh_d = 1'b1;
        if (off_complete) pend_refresh_d = 1'b0;
    end

    assign exec_if.procedure_offset_out = offset_q;
    assign exec_if.procedure_start_out  = start_q;
    assign busy_out                     = (state_q != S_IDLE);
    assign powered_out                  = powered_q;
    assign frame_done_out               = frame_done_q;
    assign error_out                    = error_q;
endmodule

// File: tb/tb_ssd1306_procedure_scheduler.sv
// Directed bench for the SSD1306 procedure scheduler with a simple executor
// model that drops procedure_done one cycle after seeing start.
module tb_ssd1306_procedure_scheduler;
    localparam int AB = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, power_on_req, power_off_req, refresh_req, auto_en;
    logic busy, powered, frame_done, error_flag;

    ssd1306_procedure_scheduler_if #(.ADDR_BITS(AB)) exec_if ();

    ssd1306_procedure_scheduler #(
        .MICROCODE_SIZE   (48),
        .OFFSET_INIT      (0),
        .OFFSET_POWER_OFF (24),
        .OFFSET_REFRESH   (36),
        .REFRESH_PERIOD   (100),
        .START_TIMEOUT    (15),
        .AUTO_INIT        (1)
    ) dut (
        .clk_in             (clk),
        .resetn_in          (resetn),
        .power_on_req_in    (power_on_req),
        .power_off_req_in   (power_off_req),
        .refresh_req_in     (refresh_req),
        .auto_refresh_en_in (auto_en),
        .exec_if            (exec_if),
        .busy_out           (busy),
        .powered_out        (powered),
        .frame_done_out     (frame_done),
        .error_out          (error_flag)
    );

    int assertions = 0;
    int failures   = 0;

    // Executor model: accepts a start one cycle later, stays busy ~30 cycles.
    logic exec_accept;
    int   exec_cnt = 0;
    always @(posedge clk) begin
        if (!resetn) begin
            exec_if.procedure_done_in <= 1'b1;
            exec_cnt <= 0;
        end else if (exec_cnt != 0) begin
            exec_cnt <= exec_cnt - 1;
            if (exec_cnt == 1) exec_if.procedure_done_in <= 1'b1;
        end else if (exec_accept && exec_if.procedure_start_out === 1'b1) begin
            exec_if.procedure_done_in <= 1'b0;
            exec_cnt <= 30;
        end
    end

    // Output monitor: start rises with their cycle/offset, high-cycle counts.
    int   cyc = 0, rises = 0, start_hi = 0, fd_hi = 0;
    logic start_prev = 1'b0;
    int   rise_cyc [64];
    int   rise_off [64];
    int   rise_fd  [64];
    always @(negedge clk) begin
        cyc++;
        if (exec_if.procedure_start_out === 1'b1) start_hi++;
        if (frame_done === 1'b1) fd_hi++;
        if (exec_if.procedure_start_out === 1'b1 && !start_prev && rises < 63) begin
            rises++;
            rise_cyc[rises] = cyc;
            rise_off[rises] = int'(exec_if.procedure_offset_out);
            rise_fd[rises]  = fd_hi;
        end
        start_prev = (exec_if.procedure_start_out === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic on, input logic off, input logic refr);
        power_on_req  = on;
        power_off_req = off;
        refresh_req   = refr;
        step(1);
        power_on_req  = 1'b0;
        power_off_req = 1'b0;
        refresh_req   = 1'b0;
    endtask

    task automatic waitRises(input int target, input int budget, input string tag);
        int n = 0;
        while (rises < target && n < budget) begin
            step(1);
            n++;
        end
        checkOutput(tag, rises, target);
    endtask

    task automatic waitPowered(input int budget, input string tag);
        int n = 0;
        while (powered !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        checkOutput(tag, powered, 1);
    endtask

    initial begin
        int base;
        int sh;
        resetn        = 1'b0;
        power_on_req  = 1'b0;
        power_off_req = 1'b0;
        refresh_req   = 1'b0;
        auto_en       = 1'b0;
        exec_accept   = 1'b1;
        exec_if.spi_ready_in = 1'b1;
        $display("[TB] reset and auto init");
        step(3);
        checkOutput("rst_offset", exec_if.procedure_offset_out, 0);
        checkOutput("rst_start", exec_if.procedure_start_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_powered", powered, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_error", error_flag, 0);
        resetn = 1'b1;
        step(1);
        checkOutput("init_start", exec_if.procedure_start_out, 1);
        checkOutput("init_offset", exec_if.procedure_offset_out, 0);
        checkOutput("init_busy", busy, 1);
        waitPowered(80, "init_powered");
        checkOutput("init_start_cycles", start_hi, 2);
        checkOutput("init_no_frame_done", fd_hi, 0);
        checkOutput("init_rises", rises, 1);
        checkOutput("init_idle", busy, 0);
        checkOutput("init_error", error_flag, 0);

        $display("[TB] periodic refresh and coalescing");
        base = rises;
        auto_en = 1'b1;
        waitRises(base + 2, 300, "auto_two_refreshes");
        checkOutput("auto_period", rise_cyc[base + 2] - rise_cyc[base + 1], 100);
        checkOutput("auto_offset1", rise_off[base + 1], 36);
        checkOutput("auto_offset2", rise_off[base + 2], 36);
        checkOutput("auto_one_frame_done", rise_fd[base + 2] - rise_fd[base + 1], 1);
        auto_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(200);
        checkOutput("coalesce_rises", rises, base + 3);
        checkOutput("coalesce_offset", rise_off[base + 3], 36);
        checkOutput("coalesce_frame_done", fd_hi - rise_fd[base + 2], 2);
        checkOutput("coalesce_idle", busy, 0);

        $display("[TB] power off beats refresh");
        base = rises;
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(2);
        checkOutput("off_busy_refresh", busy, 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        step(200);
        checkOutput("off_rises", rises, base + 2);
        checkOutput("off_first_refresh", rise_off[base + 1], 36);
        checkOutput("off_offset", rise_off[base + 2], 24);
        checkOutput("off_powered", powered, 0);
        checkOutput("off_frame_done", fd_hi - rise_fd[base + 1], 1);
        auto_en = 1'b1;
        step(250);
        checkOutput("off_timer_holds", rises, base + 2);
        auto_en = 1'b0;

        $display("[TB] unpowered requests");
        base = rises;
        exec_if.spi_ready_in = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        exec_if.spi_ready_in = 1'b1;
        step(50);
        checkOutput("unpowered_no_start", rises, base);
        checkOutput("unpowered_idle", busy, 0);
        checkOutput("unpowered_powered", powered, 0);

        $display("[TB] start timeout");
        base = rises;
        exec_accept = 1'b0;
        exec_if.spi_ready_in = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(3);
        checkOutput("timeout_blocked_by_spi", rises, base);
        sh = start_hi;
        exec_if.spi_ready_in = 1'b1;
        step(40);
        checkOutput("timeout_start_cycles", start_hi - sh, 15);
        checkOutput("timeout_error", error_flag, 1);
        checkOutput("timeout_idle", busy, 0);
        checkOutput("timeout_discarded", rises, base + 1);
        checkOutput("timeout_offset", rise_off[base + 1], 0);
        exec_accept = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitPowered(80, "retry_powered");
        checkOutput("error_sticky", error_flag, 1);

        $display("[TB] reset during procedure");
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(4);
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_start_low", exec_if.procedure_start_out, 0);
        resetn = 1'b0;
        step(1);
        checkOutput("mid_rst_start", exec_if.procedure_start_out, 0);
        checkOutput("mid_rst_offset", exec_if.procedure_offset_out, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_powered", powered, 0);
        checkOutput("mid_rst_frame_done", frame_done, 0);
        checkOutput("mid_rst_error", error_flag, 0);
        resetn = 1'b1;
        step(1);
        checkOutput("rearm_start", exec_if.procedure_start_out, 1);
        checkOutput("rearm_offset", exec_if.procedure_offset_out, 0);
        waitPowered(80, "rearm_powered");

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/ssd1306_procedure_scheduler.md
Name: ssd1306_procedure_scheduler

Overview:
Sequences the SSD1306 microcode executor. Owns its procedure_offset/procedure_start handshake. Arbitrates between three requesters: power-on (init), power-off and frame refresh (external pulse or internal periodic timer). Tracks panel power state and reports completion and errors. Sits between the application/frequency-counter logic and the microcode executor.

Parameters:
MICROCODE_SIZE, 48, executor ROM depth; ADDR_BITS = $clog2(MICROCODE_SIZE) (derived localparam)
OFFSET_INIT, 0, ROM offset of the power-up/init/display-on procedure
OFFSET_POWER_OFF, 24, ROM offset of the display-off/power-down procedure
OFFSET_REFRESH, 36, ROM offset of the frame refresh procedure
REFRESH_PERIOD, 20000, cycles between auto refresh requests (>=2)
START_TIMEOUT, 15, max cycles start may be held without acceptance
AUTO_INIT, 1, 1 = init request is pending out of reset

Ports:
clk_in  in  1  clock
resetn_in  in  1  synchronous reset, active-low
power_on_req_in  in  1  one-cycle request: run init
power_off_req_in  in  1  one-cycle request: run power-off
refresh_req_in  in  1  one-cycle request: run refresh
auto_refresh_en_in  in  1  level; enables periodic timer
procedure_done_in  in  1  executor idle (level)
spi_ready_in  in  1  SPI shifter ready
procedure_offset_out  out  ADDR_BITS  offset presented to executor
procedure_start_out  out  1  start request (registered)
busy_out  out  1  state != S_IDLE
powered_out  out  1  panel initialised and on
frame_done_out  out  1  one-cycle pulse on refresh completion
error_out  out  1  sticky start-timeout flag

Behaviour:
- Single clock clk_in; reset synchronous, active-low on resetn_in.
- Reset (resetn_in=0 at an edge): state S_IDLE; procedure_offset_out=0, procedure_start_out=0, powered_out=0, frame_done_out=0, error_out=0. pend_off=0, pend_refresh=0, pend_on=AUTO_INIT, timer=0. The top level drives the executor reset_in from ~resetn_in, so a mid-procedure reset aborts both blocks cleanly.
- Pending latches, set on request pulses:
  - pend_on: set only if !powered_out.
  - pend_refresh: set only if powered_out.
  - pend_off: set if powered_out or an init is in flight. If !powered_out and no init is in flight, power_off_req_in instead clears pend_on and runs no procedure.
  - Requests that do not qualify are dropped.
  - When a set and a dispatch-clear of the same latch coincide, set wins.
- Refresh timer (0..REFRESH_PERIOD-1):
  - Increments while powered_out && auto_refresh_en_in; otherwise holds at 0.
  - At REFRESH_PERIOD-1: wraps to 0 and sets pend_refresh.
  - Multiple refresh requests coalesce into one pending refresh.
- Priority: off > on > refresh.
- S_IDLE:
  - Dispatch when procedure_done_in && spi_ready_in && any pending latch is set.
  - Register the winner's offset and kind, clear its latch, set procedure_start_out=1, go to S_START.
  - Dispatch-to-start latency is 1 cycle.
- S_START:
  - Hold start high. On procedure_done_in=0 (accepted): start<=0, go to S_WAIT_DONE.
  - After START_TIMEOUT cycles in S_START without acceptance: start<=0, error_out<=1, go to S_IDLE. The request is discarded.
- S_WAIT_DONE, on procedure_done_in=1:
  - Kind INIT: powered_out<=1.
  - Kind OFF: powered_out<=0, pend_refresh<=0.
  - Kind REFRESH: frame_done_out pulses 1 cycle.
  - Go to S_IDLE. A new dispatch is possible no earlier than the following cycle.
- procedure_offset_out holds its last value between procedures.
- Width rule: all offsets are truncated/asserted < MICROCODE_SIZE at elaboration.

Decomposition:
- Package ssd1306_pkg holds:
  - proc_kind_t enum (KIND_INIT, KIND_OFF, KIND_REFRESH)
  - sched_state_t enum (S_IDLE, S_START, S_WAIT_DONE)
  - default offset localparams shared with the microcode ROM build
- Sub-module ssd1306_refresh_timer: period counter with enable and a one-cycle tick output.

Test Plan:
- Reset with AUTO_INIT=1, executor model goes not-done 1 cycle after start for 30 cycles -> start high exactly 2 cycles, offset=0, powered_out=1 when done returns, no frame_done_out.
- Powered, REFRESH_PERIOD=100, auto enabled -> refresh start (offset 36) every 100 cycles, frame_done_out one pulse per procedure; 3 refresh_req_in pulses during a refresh -> exactly one extra refresh.
- Powered, power_off_req_in and refresh_req_in in the same cycle while busy -> off (offset 24) dispatched first, pend_refresh discarded, powered_out=0, timer holds.
- Executor model never accepts (done stuck 1, spi_ready 0 then 1) -> start held 15 cycles, error_out=1 sticky, busy_out=0.
- refresh_req_in while unpowered -> ignored. power_off_req_in while unpowered with init pending -> pend_on cleared, no start issued.
- resetn_in=0 mid S_WAIT_DONE -> next cycle all outputs at reset values, pend_on re-armed.
